// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer slice.
// Holds the opcode and sequencer state encodings, the datapath mux select
// constants, the write-strobe bundle type and the program counter increment helper.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_00  = 4'd0,
      OP_01  = 4'd1,
      OP_02  = 4'd2,
      OP_03  = 4'd3,
      OP_04  = 4'd4,
      OP_05  = 4'd5,
      OP_06  = 4'd6,
      OP_07  = 4'd7,
      OP_08  = 4'd8,
      OP_09  = 4'd9,
      OP_10  = 4'd10,
      OP_11  = 4'd11,
      OP_JMP = 4'd12,
      OP_JZ  = 4'd13,
      OP_NOP = 4'd14,
      OP_HLT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } seq_state_e;

   // Datapath input mux: immediate operand vs. normal register path
   localparam logic [1:0] MUX_IMM = 2'b11;
   localparam logic [1:0] MUX_REG = 2'b00;

   typedef struct packed {
      logic write_a;
      logic write_b;
      logic write_o;
      logic write_cz;
   } strobe_t;

   // Program counter increment; the 4-bit result wraps 15 -> 0 on purpose
   function automatic logic [3:0] pc_inc(input logic [3:0] pc);
      return pc + 4'd1;
   endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder.
// Ports:
//   opcode  in  4  opcode to decode
//   strobes out    register write strobes the opcode would raise in WRITEBACK
//   mux_sel out 2  datapath mux select the opcode needs in EXECUTE/WRITEBACK
module opcode_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output strobe_t    strobes,
   output logic [1:0] mux_sel
);

   // Opcode to strobe/mux table
   always_comb begin
      strobes = '0;
      mux_sel = MUX_REG;
      case (opcode_e'(opcode))
         OP_00: begin
            strobes.write_cz = 1'b1;
         end
         OP_01: begin
            strobes.write_a  = 1'b1;
            strobes.write_cz = 1'b1;
            mux_sel          = MUX_IMM;
         end
         OP_02: begin
            strobes.write_a = 1'b1;
            strobes.write_o = 1'b1;
         end
         OP_03: begin
            strobes.write_a  = 1'b1;
            strobes.write_cz = 1'b1;
         end
         OP_04: begin
            strobes.write_b  = 1'b1;
            strobes.write_cz = 1'b1;
         end
         OP_05: begin
            strobes.write_b = 1'b1;
         end
         OP_06, OP_07, OP_08, OP_09, OP_10, OP_11: begin
            strobes.write_a  = 1'b1;
            strobes.write_cz = 1'b1;
         end
         OP_JMP, OP_JZ, OP_NOP, OP_HLT: begin
            strobes = '0;
         end
         default: begin
            strobes = '0;
            mux_sel = MUX_REG;
         end
      endcase
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: steps a 4-bit program counter through a program ROM,
// running each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
// Ports:
//   Clock      in   1  sole clock, rising edge
//   Reset_n    in   1  synchronous active-low reset
//   Run        in   1  free-run back-to-back instructions while high
//   Step       in   1  rising edge requests one instruction while idle
//   Instr      in   8  ROM data ([7:4] opcode, [3:0] immediate), one cycle after PC_Addr
//   Zflag      in   1  zero flag, sampled during EXECUTE
//   PC_Addr    out  4  program counter / ROM address
//   f_4        out  4  latched opcode (ALU function)
//   Immediate  out  4  latched immediate
//   MuxSelect  out  2  datapath input mux select
//   WriteA/B/O/CZ out 1 register write strobes, WRITEBACK only
//   Busy       out  1  high outside IDLE and HALT
//   Halted     out  1  high in HALT
module instruction_sequencer
   import cpu_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       Run,
   input  logic       Step,
   input  logic [7:0] Instr,
   input  logic       Zflag,
   output logic [3:0] PC_Addr,
   output logic [3:0] f_4,
   output logic [3:0] Immediate,
   output logic [1:0] MuxSelect,
   output logic       WriteA,
   output logic       WriteB,
   output logic       WriteO,
   output logic       WriteCZ,
   output logic       Busy,
   output logic       Halted
);

   seq_state_e state_r;
   seq_state_e state_next_s;
   logic [3:0] pc_r;
   logic [3:0] pc_next_s;
   logic [7:0] ir_r;
   logic       step_d_r;
   logic       step_rise_s;
   logic       zflag_r;
   logic [3:0] op_src_s;
   opcode_e    ir_op_s;
   strobe_t    dec_strobe_s;
   strobe_t    strobe_next_s;
   strobe_t    strobe_r;
   logic [1:0] dec_mux_s;
   logic [1:0] mux_next_s;
   logic [1:0] mux_r;
   logic       busy_next_s;
   logic       busy_r;
   logic       halted_next_s;
   logic       halted_r;

   assign step_rise_s = Step & ~step_d_r;
   assign ir_op_s     = opcode_e'(ir_r[7:4]);

   // Decoder source: the ROM word while it is being latched, the IR afterwards,
   // so the registered mux select is already valid on entry to EXECUTE
   always_comb begin
      op_src_s = ir_r[7:4];
      if (state_r == ST_DECODE) begin
         op_src_s = Instr[7:4];
      end else begin
         op_src_s = ir_r[7:4];
      end
   end

   opcode_decoder u_opcode_decoder (
      .opcode  (op_src_s),
      .strobes (dec_strobe_s),
      .mux_sel (dec_mux_s)
   );

   // Next-state logic; a Step edge only counts while idle and Run takes precedence
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Run || step_rise_s) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_next_s = ST_DECODE;
         end
         ST_DECODE: begin
            if (opcode_e'(Instr[7:4]) == OP_HLT) begin
               state_next_s = ST_HALT;
            end else begin
               state_next_s = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            state_next_s = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            if (Run) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_HALT: begin
            state_next_s = ST_HALT;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Program counter update, applied on the edge leaving WRITEBACK
   always_comb begin
      pc_next_s = pc_r;
      if (state_r == ST_WRITEBACK) begin
         case (ir_op_s)
            OP_JMP: begin
               pc_next_s = ir_r[3:0];
            end
            OP_JZ: begin
               if (zflag_r) begin
                  pc_next_s = ir_r[3:0];
               end else begin
                  pc_next_s = pc_inc(pc_r);
               end
            end
            default: begin
               pc_next_s = pc_inc(pc_r);
            end
         endcase
      end else begin
         pc_next_s = pc_r;
      end
   end

   // Output values for the coming state; registering them keeps strobes glitch-free
   always_comb begin
      strobe_next_s = '0;
      mux_next_s    = MUX_REG;
      busy_next_s   = 1'b0;
      halted_next_s = 1'b0;
      if (state_next_s == ST_WRITEBACK) begin
         strobe_next_s = dec_strobe_s;
      end else begin
         strobe_next_s = '0;
      end
      if ((state_next_s == ST_EXECUTE) || (state_next_s == ST_WRITEBACK)) begin
         mux_next_s = dec_mux_s;
      end else begin
         mux_next_s = MUX_REG;
      end
      if ((state_next_s == ST_IDLE) || (state_next_s == ST_HALT)) begin
         busy_next_s = 1'b0;
      end else begin
         busy_next_s = 1'b1;
      end
      if (state_next_s == ST_HALT) begin
         halted_next_s = 1'b1;
      end else begin
         halted_next_s = 1'b0;
      end
   end

   // State, PC, IR and output registers with synchronous reset
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_r  <= ST_IDLE;
         pc_r     <= 4'd0;
         ir_r     <= 8'd0;
         step_d_r <= 1'b0;
         zflag_r  <= 1'b0;
         strobe_r <= '0;
         mux_r    <= MUX_REG;
         busy_r   <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         pc_r     <= pc_next_s;
         step_d_r <= Step;
         if (state_r == ST_DECODE) begin
            ir_r <= Instr;
         end
         if (state_r == ST_EXECUTE) begin
            zflag_r <= Zflag;
         end
         strobe_r <= strobe_next_s;
         mux_r    <= mux_next_s;
         busy_r   <= busy_next_s;
         halted_r <= halted_next_s;
      end
   end

   assign PC_Addr   = pc_r;
   assign f_4       = ir_r[7:4];
   assign Immediate = ir_r[3:0];
   assign MuxSelect = mux_r;
   assign WriteA    = strobe_r.write_a;
   assign WriteB    = strobe_r.write_b;
   assign WriteO    = strobe_r.write_o;
   assign WriteCZ   = strobe_r.write_cz;
   assign Busy      = busy_r;
   assign Halted    = halted_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: a registered ROM model feeds the
// DUT, tasks queue expected per-instruction results, and a monitor pops and
// compares them as each instruction reaches EXECUTE and WRITEBACK.
module tb_instruction_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       run;
   logic       step;
   logic [7:0] instr;
   logic       zflag;
   logic [3:0] pc_addr;
   logic [3:0] f_4;
   logic [3:0] immediate;
   logic [1:0] muxselect;
   logic       write_a, write_b, write_o, write_cz;
   logic       busy, halted;
   logic [3:0] strb;

   logic [7:0] rom [16];

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] imm;
      logic [3:0] strb;
      logic [1:0] mux;
      logic [3:0] next_pc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   assign strb = {write_a, write_b, write_o, write_cz};

   always #5 clk = ~clk;

   // Synchronous program ROM: data appears one cycle after the address
   always @(posedge clk) instr <= rom[pc_addr];

   instruction_sequencer dut (
      .Clock     (clk),
      .Reset_n   (reset_n),
      .Run       (run),
      .Step      (step),
      .Instr     (instr),
      .Zflag     (zflag),
      .PC_Addr   (pc_addr),
      .f_4       (f_4),
      .Immediate (immediate),
      .MuxSelect (muxselect),
      .WriteA    (write_a),
      .WriteB    (write_b),
      .WriteO    (write_o),
      .WriteCZ   (write_cz),
      .Busy      (busy),
      .Halted    (halted)
   );

   // Strobe table in {A,B,O,CZ} order
   function automatic logic [3:0] model_strobes(input logic [3:0] op);
      case (op)
         4'd0:  return 4'b0001;
         4'd1:  return 4'b1001;
         4'd2:  return 4'b1010;
         4'd3:  return 4'b1001;
         4'd4:  return 4'b0101;
         4'd5:  return 4'b0100;
         4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: return 4'b1001;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic push_instr(input logic [3:0] pc, input logic z, output logic [3:0] nxt);
      exp_t e;
      logic [7:0] w;
      w = rom[pc];
      e.op   = w[7:4];
      e.imm  = w[3:0];
      e.strb = model_strobes(w[7:4]);
      e.mux  = (w[7:4] == 4'd1) ? 2'b11 : 2'b00;
      if (w[7:4] == 4'd12) nxt = w[3:0];
      else if ((w[7:4] == 4'd13) && z) nxt = w[3:0];
      else nxt = pc + 4'd1;
      e.next_pc = nxt;
      sb.push_back(e);
   endtask

   // Busy-cycle phase 0..3 = FETCH, DECODE, EXECUTE, WRITEBACK
   task automatic run_monitor();
      int         phase = 0;
      logic       pc_pend = 1'b0;
      logic [3:0] pc_exp = 4'd0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            phase   = 0;
            pc_pend = 1'b0;
         end else begin
            if (pc_pend) begin
               checks++;
               if (pc_addr !== pc_exp) begin
                  errors++;
                  $display("FAIL sb_next_pc: PC_Addr=%0d expected %0d", pc_addr, pc_exp);
               end
               pc_pend = 1'b0;
            end
            if (busy === 1'b1 && (phase == 2 || phase == 3)) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_underflow: unexpected instruction in phase %0d at PC_Addr=%0d", phase, pc_addr);
               end else begin
                  e = sb[0];
                  if (phase == 2) begin
                     if ({f_4, immediate, muxselect, strb} !== {e.op, e.imm, e.mux, 4'b0000}) begin
                        errors++;
                        $display("FAIL sb_execute: f_4/imm/mux/strb=%h/%h/%b/%b expected %h/%h/%b/0000",
                                 f_4, immediate, muxselect, strb, e.op, e.imm, e.mux);
                     end
                  end else begin
                     void'(sb.pop_front());
                     if ({muxselect, strb} !== {e.mux, e.strb}) begin
                        errors++;
                        $display("FAIL sb_writeback: op=%0d mux/strb=%b/%b expected %b/%b",
                                 e.op, muxselect, strb, e.mux, e.strb);
                     end
                     pc_pend = 1'b1;
                     pc_exp  = e.next_pc;
                  end
               end
            end else begin
               checks++;
               if ({muxselect, strb} !== 6'b000000) begin
                  errors++;
                  $display("FAIL quiet_outputs: mux/strb=%b/%b outside EXECUTE/WRITEBACK", muxselect, strb);
               end
            end
            if (busy === 1'b1) phase = (phase == 3) ? 0 : phase + 1;
            else phase = 0;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      run     = 1'b0;
      step    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      reset_n = 1'b1;
   endtask

   task automatic wait_done(input string name, input int max);
      int n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < max) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL %s_timeout: waited %0d cycles, limit %0d, pending=%0d", name, n, max, sb.size());
      end
   endtask

   task automatic step_pulse();
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset_n = 1'b0; run = 1'b1; step = 1'b1; zflag = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({pc_addr, f_4, immediate, muxselect, strb, busy, halted} !== 20'd0) begin
         errors++;
         $display("FAIL reset_values: outputs=%h expected 0", {pc_addr, f_4, immediate, muxselect, strb, busy, halted});
      end
      @(posedge clk); #1;
      run = 1'b0; step = 1'b0; zflag = 1'b0; reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, halted, pc_addr} !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle: busy/halted/pc=%b/%b/%0d expected 0/0/0", busy, halted, pc_addr);
      end
   endtask

   task automatic test_step_single();
      logic [3:0] nxt;
      do_reset();
      rom[0] = 8'h13;
      push_instr(4'd0, 1'b0, nxt);
      step_pulse();                     // now in FETCH
      repeat (3) @(posedge clk);        // DECODE, EXECUTE, WRITEBACK
      @(negedge clk);
      checks++;
      if ({strb, muxselect} !== 6'b1001_11) begin
         errors++;
         $display("FAIL step_writeback: strb/mux=%b/%b expected 1001/11", strb, muxselect);
      end
      @(negedge clk);
      checks++;
      if ({strb, busy, pc_addr} !== {4'b0000, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL step_after: strb/busy/pc=%b/%b/%0d expected 0000/0/1", strb, busy, pc_addr);
      end
      wait_done("step_single", 20);
   endtask

   task automatic test_run_program();
      logic [3:0] pc;
      do_reset();
      rom[0] = 8'h20; rom[1] = 8'h55; rom[2] = 8'hF0;
      pc = 4'd0;
      push_instr(pc, 1'b0, pc);
      push_instr(pc, 1'b0, pc);
      @(posedge clk); #1 run = 1'b1;
      wait_done("run_program", 40);
      repeat (5) @(negedge clk);
      checks++;
      if ({halted, busy, pc_addr, strb} !== {1'b1, 1'b0, 4'd2, 4'b0000}) begin
         errors++;
         $display("FAIL halt_state: halted/busy/pc/strb=%b/%b/%0d/%b expected 1/0/2/0000", halted, busy, pc_addr, strb);
      end
      @(posedge clk); #1 run = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({halted, pc_addr} !== {1'b1, 4'd2}) begin
         errors++;
         $display("FAIL halt_sticky: halted/pc=%b/%0d expected 1/2", halted, pc_addr);
      end
   endtask

   task automatic test_strobe_table();
      logic [3:0] pc;
      logic [3:0] hi, lo;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         hi = 4'(i);
         lo = 4'(15 - i);
         rom[i] = {hi, lo};
      end
      rom[12] = 8'hCE; rom[13] = 8'h00; rom[14] = 8'hF0;
      pc = 4'd0;
      for (int k = 0; k < 13; k++) push_instr(pc, 1'b0, pc);
      @(posedge clk); #1 run = 1'b1;
      wait_done("strobe_table", 120);
      checks++;
      if ({halted, pc_addr} !== {1'b1, 4'd14}) begin
         errors++;
         $display("FAIL jmp_then_halt: halted/pc=%b/%0d expected 1/14", halted, pc_addr);
      end
      @(posedge clk); #1 run = 1'b0;
   endtask

   task automatic test_jz();
      logic [3:0] nxt;
      logic [3:0] want;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         rom[0] = 8'hD7;
         zflag  = (t == 0);
         want   = (t == 0) ? 4'd7 : 4'd1;
         push_instr(4'd0, zflag, nxt);
         step_pulse();                  // FETCH
         repeat (3) @(posedge clk);     // WRITEBACK: flag already sampled
         #1 zflag = ~zflag;
         wait_done("jz", 20);
         checks++;
         if (pc_addr !== want) begin
            errors++;
            $display("FAIL jz_target: PC_Addr=%0d expected %0d (z=%0d)", pc_addr, want, (t == 0));
         end
      end
      zflag = 1'b0;
   endtask

   task automatic test_wrap();
      logic [3:0] pc;
      int n;
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
      pc = 4'd0;
      for (int k = 0; k < 17; k++) push_instr(pc, 1'b0, pc);
      @(posedge clk); #1 run = 1'b1;
      n = 0;
      while (sb.size() > 1 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1 run = 1'b0;
      wait_done("wrap", 30);
      checks++;
      if ({busy, pc_addr} !== {1'b0, 4'd1}) begin
         errors++;
         $display("FAIL wrap_end: busy/pc=%b/%0d expected 0/1", busy, pc_addr);
      end
   endtask

   task automatic test_step_ignored();
      logic [3:0] pc;
      do_reset();
      rom[0] = 8'h6A; rom[1] = 8'hB5;
      pc = 4'd0;
      push_instr(pc, 1'b0, pc);
      step_pulse();                     // FETCH
      @(posedge clk); #1;               // DECODE
      @(posedge clk); #1 step = 1'b1;   // EXECUTE: edge must be ignored
      @(posedge clk); #1 step = 1'b0;   // WRITEBACK
      repeat (6) @(negedge clk);
      checks++;
      if ({busy, pc_addr} !== {1'b0, 4'd1} || sb.size() != 0) begin
         errors++;
         $display("FAIL step_in_execute: busy/pc=%b/%0d pending=%0d expected 0/1/0", busy, pc_addr, sb.size());
      end
      push_instr(pc, 1'b0, pc);
      @(posedge clk); #1 run = 1'b1; step = 1'b1;
      @(posedge clk); #1 run = 1'b0;
      wait_done("run_step", 20);
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, pc_addr} !== {1'b0, 4'd2} || sb.size() != 0) begin
         errors++;
         $display("FAIL run_and_step: busy/pc=%b/%0d pending=%0d expected 0/2/0", busy, pc_addr, sb.size());
      end
      step = 1'b0;
   endtask

   task automatic test_reset_wb();
      logic [3:0] nxt;
      do_reset();
      rom[0] = 8'h4C;
      push_instr(4'd0, 1'b0, nxt);
      step_pulse();                     // FETCH
      repeat (3) @(posedge clk);        // WRITEBACK
      #1 reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if (strb !== 4'b0101) begin
         errors++;
         $display("FAIL wb_before_reset: strb=%b expected 0101", strb);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      sb.delete();
      @(negedge clk);
      checks++;
      if ({strb, pc_addr, busy, halted} !== 10'd0) begin
         errors++;
         $display("FAIL reset_in_wb: strb/pc/busy/halted=%b/%0d/%b/%b expected 0000/0/0/0", strb, pc_addr, busy, halted);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, pc_addr} !== 5'd0) begin
         errors++;
         $display("FAIL reset_in_wb_idle: busy/pc=%b/%0d expected 0/0", busy, pc_addr);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      run     = 1'b0;
      step    = 1'b0;
      zflag   = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
      fork
         run_monitor();
      join_none
      test_reset();
      test_step_single();
      test_run_program();
      test_strobe_table();
      test_jz();
      test_wrap();
      test_step_ignored();
      test_reset_wb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
